// File: rtl/layer_mac_sequencer_if.sv
// Bundles the layer sequencer's run control, weight-memory read port and result stream.
// No latency of its own; it only groups signals.
// No backpressure: the consumer must accept every out_valid strobe.
interface layer_mac_sequencer_if #(
    parameter int NODES  = 16,
    parameter int INPUTS = 15,
    parameter int DW     = 16
);
    localparam int AW = $clog2(NODES * (INPUTS + 1));
    localparam int IW = $clog2(NODES);

    logic                 start;
    logic [INPUTS*DW-1:0] in_vec;
    logic                 w_rd_en;
    logic [AW-1:0]        w_addr;
    logic [DW-1:0]        w_data;
    logic                 out_valid;
    logic [IW-1:0]        out_idx;
    logic [DW-1:0]        out_data;
    logic                 busy;
    logic                 done;

    // Requester side: drives the run, serves weight reads, consumes results.
    modport master (
        output start, in_vec, w_data,
        input  w_rd_en, w_addr, out_valid, out_idx, out_data, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, in_vec, w_data,
        output w_rd_en, w_addr, out_valid, out_idx, out_data, busy, done
    );
endinterface

// File: rtl/layer_mac_sequencer.sv
// One shared MAC walks NODES neurons: INPUTS weighted products plus bias, ReLU, one result strobe each.
// First result INPUTS+3 cycles after the start edge, then one every INPUTS+3 cycles; done on the last.
// No backpressure: results are strobed once; start is ignored while a run is active or on the done cycle.
module layer_mac_sequencer #(
    parameter int NODES  = 16,
    parameter int INPUTS = 15,
    parameter int DW     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    layer_mac_sequencer_if.slave  bus
);
    localparam int AW = $clog2(NODES * (INPUTS + 1));
    localparam int IW = $clog2(NODES);
    localparam int KW = $clog2(INPUTS + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, EMIT} state_t;

    state_t               state_q;
    logic [INPUTS*DW-1:0] vec_q;
    logic [IW-1:0]        node_q;
    logic [KW-1:0]        k_q;
    logic                 rd_en_q;
    logic [AW-1:0]        addr_q;
    logic [KW-1:0]        rd_k_q;     // element index of the read on the bus this cycle
    logic                 pend_vld_q; // read data for pend_k_q arrives on w_data this cycle
    logic [KW-1:0]        pend_k_q;
    logic [DW-1:0]        acc_q;
    logic                 out_valid_q;
    logic [IW-1:0]        out_idx_q;
    logic [DW-1:0]        out_data_q;
    logic                 busy_q;
    logic                 done_q;

    logic [KW-1:0]        sel;
    logic [DW-1:0]        act;
    logic signed [2*DW-1:0] prod;
    logic [DW-1:0]        term;
    logic [DW-1:0]        acc_d;
    logic [AW-1:0]        addr_d;

    // Accumulator next value: weighted activation, or the raw bias for the last element of a neuron.
    always_comb begin
        sel    = (pend_k_q == KW'(INPUTS)) ? '0 : pend_k_q;
        act    = vec_q[sel*DW +: DW];
        prod   = $signed(act) * $signed(bus.w_data);
        term   = (pend_k_q == KW'(INPUTS)) ? bus.w_data : prod[DW-1:0];
        acc_d  = pend_vld_q ? acc_q + term : acc_q;
        addr_d = AW'(node_q) * AW'(INPUTS + 1) + AW'(k_q);
    end

    // Sequencer FSM, read pipeline tracking, accumulator and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            node_q      <= '0;
            k_q         <= '0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            rd_k_q      <= '0;
            pend_vld_q  <= 1'b0;
            pend_k_q    <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pend_vld_q  <= rd_en_q;
            pend_k_q    <= rd_k_q;
            acc_q       <= acc_d;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            // busy spans the done strobe, so a start coincident with done is still refused.
            if (done_q) begin
                busy_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (bus.start && !busy_q) begin
                        vec_q   <= bus.in_vec;
                        node_q  <= '0;
                        k_q     <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    rd_en_q <= 1'b1;
                    addr_q  <= addr_d;
                    rd_k_q  <= k_q;
                    if (k_q == KW'(INPUTS)) begin
                        k_q     <= '0;
                        state_q <= DRAIN;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DRAIN: begin
                    state_q <= EMIT;
                end
                default: begin // EMIT: bias lands this cycle, so the result uses acc_d
                    out_valid_q <= 1'b1;
                    out_idx_q   <= node_q;
                    out_data_q  <= acc_d[DW-1] ? '0 : acc_d;
                    acc_q       <= '0;
                    k_q         <= '0;
                    if (node_q == IW'(NODES - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        node_q  <= node_q + 1'b1;
                        state_q <= ISSUE;
                    end
                end
            endcase
        end
    end

    assign bus.w_rd_en   = rd_en_q;
    assign bus.w_addr    = addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Bench for layer_mac_sequencer: weight memory model, run driver, per-scenario checks against a dot-product model.
// Cycle n of a run = number of rising edges after the edge that sampled start, observed at the falling edge.
// Results are never stalled; the bench records every strobe.
module tb_layer_mac_sequencer;
    localparam int NODES  = 16;
    localparam int INPUTS = 15;
    localparam int DW     = 16;
    localparam int PER    = INPUTS + 3;
    localparam int WORDS  = NODES * (INPUTS + 1);
    localparam int RUN    = NODES * PER;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    layer_mac_sequencer_if #(.NODES(NODES), .INPUTS(INPUTS), .DW(DW)) bus ();
    layer_mac_sequencer #(.NODES(NODES), .INPUTS(INPUTS), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [WORDS];
    logic [DW-1:0] vin [INPUTS];

    // Synchronous weight memory: data one cycle after the read strobe.
    always @(posedge clk) if (bus.w_rd_en) bus.w_data <= mem[bus.w_addr];

    int            ev_n[$];
    int            ev_idx[$];
    logic [DW-1:0] ev_dat[$];
    int            done_n[$];
    int            busy_low_n;
    int            first_rd_n;
    int            rd_cnt;
    int            rd_bad;

    // Reference: dot product with each product truncated to DW bits, plus bias, mod 2^DW, then ReLU.
    function automatic logic [DW-1:0] model(int n);
        int s;
        logic [DW-1:0] r;
        s = 0;
        for (int k = 0; k < INPUTS; k++)
            s += int'($signed(vin[k])) * int'($signed(mem[n*(INPUTS+1)+k]));
        s += int'(mem[n*(INPUTS+1)+INPUTS]);
        r = s[DW-1:0];
        return r[DW-1] ? '0 : r;
    endfunction

    // Drives one run and records strobes; reads must walk the memory 0,1,2,... in order.
    task automatic do_run(input int restart_at, input int reset_at, input int vec_at,
                          input bit start_on_done);
        int c0;
        int n;
        bit seen_done;
        ev_n.delete(); ev_idx.delete(); ev_dat.delete(); done_n.delete();
        busy_low_n = -1; first_rd_n = -1; rd_cnt = 0; rd_bad = 0; seen_done = 0;
        for (int j = 0; j < INPUTS; j++) bus.in_vec[j*DW +: DW] = vin[j];
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        c0 = cyc;
        bus.start = 1'b0;
        for (int i = 0; i < RUN + 40; i++) begin
            @(negedge clk);
            n = cyc - c0;
            if (bus.w_rd_en) begin
                if (first_rd_n < 0) first_rd_n = n;
                if (int'(bus.w_addr) != rd_cnt) rd_bad++;
                rd_cnt++;
            end
            if (bus.out_valid) begin
                ev_n.push_back(n); ev_idx.push_back(int'(bus.out_idx)); ev_dat.push_back(bus.out_data);
            end
            if (bus.done) done_n.push_back(n);
            bus.start = (n == restart_at);
            if (n == vec_at)
                for (int j = 0; j < INPUTS; j++) bus.in_vec[j*DW +: DW] = 16'($urandom);
            if (n == reset_at) begin
                reset = 1'b0;
                return;
            end
            if (bus.done) begin
                seen_done = 1;
                if (start_on_done) bus.start = 1'b1;
            end
            if (seen_done && !bus.busy) begin
                busy_low_n = n;
                bus.start = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.out_valid, bus.done, bus.w_rd_en} !== 4'b0)
            begin errors++; $display("FAIL reset_ctrl got %b want 0000", {bus.busy, bus.out_valid, bus.done, bus.w_rd_en}); end
        checks++;
        if (bus.out_idx !== '0 || bus.out_data !== '0 || bus.w_addr !== '0)
            begin errors++; $display("FAIL reset_data got idx %0d data %0d addr %0d want 0", bus.out_idx, bus.out_data, bus.w_addr); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL idle_after_reset busy %b valid %b want 0 0", bus.busy, bus.out_valid); end
    endtask

    task automatic test_bias_timing;
        for (int a = 0; a < WORDS; a++) mem[a] = (a % (INPUTS+1) == INPUTS) ? 16'd260 : 16'd0;
        for (int j = 0; j < INPUTS; j++) vin[j] = 16'($urandom);
        do_run(-1, -1, -1, 0);
        checks++;
        if (ev_n.size() != NODES) begin errors++; $display("FAIL bias_count got %0d want %0d", ev_n.size(), NODES); end
        for (int i = 0; i < ev_n.size() && i < NODES; i++) begin
            checks++;
            if (ev_n[i] != PER*(i+1) || ev_idx[i] != i || ev_dat[i] !== 16'd260)
                begin errors++; $display("FAIL bias_pulse%0d got cyc %0d idx %0d data %0d want %0d %0d 260", i, ev_n[i], ev_idx[i], ev_dat[i], PER*(i+1), i); end
        end
        checks++;
        if (done_n.size() != 1 || done_n[0] != RUN)
            begin errors++; $display("FAIL done_cycle got %0d pulses first %0d want 1 at %0d", done_n.size(), (done_n.size() > 0) ? done_n[0] : -1, RUN); end
        checks++;
        if (busy_low_n != RUN + 1) begin errors++; $display("FAIL busy_low got %0d want %0d", busy_low_n, RUN + 1); end
        checks++;
        if (first_rd_n != 1 || rd_cnt != WORDS || rd_bad != 0)
            begin errors++; $display("FAIL read_seq got first %0d count %0d bad %0d want 1 %0d 0", first_rd_n, rd_cnt, rd_bad, WORDS); end
    endtask

    task automatic test_known_neuron;
        int w0[INPUTS] = '{1007, 564, 186, -314, -335, -48, 126, 492, -172, -529, -279, -564, 109, 997, 176};
        for (int a = 0; a < WORDS; a++) mem[a] = 16'($urandom);
        for (int k = 0; k < INPUTS; k++) mem[k] = 16'(w0[k]);
        mem[INPUTS] = 16'd260;
        for (int j = 0; j < INPUTS; j++) vin[j] = 16'd1;
        do_run(-1, -1, -1, 0);
        checks++;
        if (ev_dat.size() < 1 || ev_idx[0] != 0 || ev_dat[0] !== 16'd1676)
            begin errors++; $display("FAIL node0_sum got idx %0d data %0d want 0 1676", (ev_idx.size() > 0) ? ev_idx[0] : -1, (ev_dat.size() > 0) ? ev_dat[0] : 16'hx); end
    endtask

    task automatic test_relu_clamp;
        int bad;
        bad = 0;
        for (int a = 0; a < WORDS; a++) mem[a] = (a % (INPUTS+1) == INPUTS) ? 16'hFFFF : 16'd0;
        for (int j = 0; j < INPUTS; j++) vin[j] = 16'($urandom);
        do_run(-1, -1, -1, 0);
        foreach (ev_dat[i]) if (ev_dat[i] !== 16'd0) bad++;
        checks++;
        if (bad != 0 || ev_dat.size() != NODES)
            begin errors++; $display("FAIL relu_clamp got %0d nonzero of %0d want 0 of %0d", bad, ev_dat.size(), NODES); end
    endtask

    task automatic test_product_wrap;
        int bad;
        bad = 0;
        for (int a = 0; a < WORDS; a++) mem[a] = 16'd0;
        for (int n = 0; n < NODES; n++) begin
            mem[n*(INPUTS+1)]        = 16'h0100;
            mem[n*(INPUTS+1)+INPUTS] = 16'd5;
        end
        for (int j = 0; j < INPUTS; j++) vin[j] = 16'($urandom);
        vin[0] = 16'h0100;
        do_run(-1, -1, -1, 0);
        foreach (ev_dat[i]) if (ev_dat[i] !== 16'd5) bad++;
        checks++;
        if (bad != 0 || ev_dat.size() != NODES)
            begin errors++; $display("FAIL product_wrap got %0d wrong of %0d want 0 of %0d", bad, ev_dat.size(), NODES); end
    endtask

    // Random weights and activations; in_vec is scrambled mid-run and must not matter.
    task automatic test_random;
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < WORDS; a++) mem[a] = 16'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 600) - 300);
            for (int j = 0; j < INPUTS; j++) vin[j] = 16'($urandom_range(0, 200) - 100);
            do_run(-1, -1, 5, 0);
            checks++;
            if (ev_dat.size() != NODES) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", r, ev_dat.size(), NODES); end
            for (int i = 0; i < ev_dat.size() && i < NODES; i++) begin
                checks++;
                if (ev_idx[i] != i || ev_dat[i] !== model(i))
                    begin errors++; $display("FAIL rand%0d_node%0d got idx %0d data %0d want %0d %0d", r, i, ev_idx[i], ev_dat[i], i, model(i)); end
            end
        end
    endtask

    task automatic test_start_while_busy;
        do_run(50, -1, -1, 0);
        checks++;
        if (ev_n.size() != NODES || ev_n[NODES-1] != RUN || busy_low_n != RUN + 1)
            begin errors++; $display("FAIL restart_ignored got %0d pulses busy_low %0d want %0d %0d", ev_n.size(), busy_low_n, NODES, RUN + 1); end
    endtask

    task automatic test_start_on_done;
        int act;
        act = 0;
        do_run(-1, -1, -1, 1);
        repeat (10) begin
            @(negedge clk);
            if (bus.busy || bus.w_rd_en || bus.out_valid) act++;
        end
        checks++;
        if (busy_low_n != RUN + 1 || act != 0)
            begin errors++; $display("FAIL start_on_done got busy_low %0d active %0d want %0d 0", busy_low_n, act, RUN + 1); end
    endtask

    task automatic test_reset_mid_run;
        int strobes;
        strobes = 0;
        for (int a = 0; a < WORDS; a++) mem[a] = 16'($urandom_range(0, 100));
        for (int j = 0; j < INPUTS; j++) vin[j] = 16'($urandom_range(0, 50));
        do_run(-1, 100, -1, 0);
        #1;
        checks++;
        if ({bus.busy, bus.out_valid, bus.done, bus.w_rd_en} !== 4'b0)
            begin errors++; $display("FAIL reset_abort got %b want 0000", {bus.busy, bus.out_valid, bus.done, bus.w_rd_en}); end
        checks++;
        if (ev_n.size() != 5) begin errors++; $display("FAIL reset_prior got %0d strobes want 5", ev_n.size()); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) strobes++;
        end
        checks++;
        if (strobes != 0) begin errors++; $display("FAIL reset_quiet got %0d active cycles want 0", strobes); end
        do_run(-1, -1, -1, 0);
        checks++;
        if (ev_n.size() != NODES || ev_n[0] != PER || ev_idx[0] != 0 || ev_dat[0] !== model(0) || busy_low_n != RUN + 1)
            begin errors++; $display("FAIL rerun got %0d pulses first cyc %0d busy_low %0d want %0d %0d %0d", ev_n.size(), (ev_n.size() > 0) ? ev_n[0] : -1, busy_low_n, NODES, PER, RUN + 1); end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.in_vec = '0;
        bus.w_data = '0;
        test_reset();
        test_bias_timing();
        test_known_neuron();
        test_relu_clamp();
        test_product_wrap();
        test_random();
        test_start_while_busy();
        test_start_on_done();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
